// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Shadow entries are sized for the widest register index any instance may use.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int HZ_AW_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [HZ_AW_MAX-1:0] dst;
    logic [HZ_AW_MAX-1:0] rs;
    logic [HZ_AW_MAX-1:0] rt;
    logic                 regwrite;
    logic                 memread;
  } shadow_t;

  function automatic shadow_t shadow_clear();
    shadow_t e;
    e = {$bits(shadow_t){1'b0}};
    return e;
  endfunction

endpackage

// File: rtl/hilo_busy_counter.sv
// Down-counter tracking how long the HI/LO multiply/divide result stays unavailable.
module hilo_busy_counter
  import hazard_pkg::*;
#(
  parameter int HILO_LAT = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic start,
  output logic busy
);

  localparam int CNT_W = $clog2(HILO_LAT + 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(HILO_LAT);
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != {CNT_W{1'b0}});

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use and HI/LO
// stalls, redirect squashes and EX operand forwarding from a shadow of EX/MEM/WB.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int HILO_LAT = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_hilo_op,
  input  logic              id_hilo_read,
  input  logic              ex_redirect,
  output logic              stall_pc,
  output logic              bubble_ex,
  output logic              flush_dec,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              hilo_busy
);

  shadow_t ex_d, ex_q;
  shadow_t mem_d, mem_q;
  shadow_t wb_d, wb_q;

  logic [HZ_AW_MAX-1:0] rs_w;
  logic [HZ_AW_MAX-1:0] rt_w;
  logic [HZ_AW_MAX-1:0] dst_w;
  logic                 load_haz;
  logic                 hilo_haz;
  logic                 stall;
  logic                 issue;
  logic                 hilo_start;
  logic                 cnt_busy;
  logic [1:0]           fwd_a_raw;
  logic [1:0]           fwd_b_raw;

  function automatic logic [HZ_AW_MAX-1:0] widen(input logic [REG_AW-1:0] r);
    logic [HZ_AW_MAX-1:0] w;
    w = {HZ_AW_MAX{1'b0}};
    w[REG_AW-1:0] = r;
    return w;
  endfunction

  // $zero is hard-wired, so a producer targeting it never matches a consumer.
  function automatic logic match(input shadow_t e, input logic [HZ_AW_MAX-1:0] r);
    return e.valid & e.regwrite & (e.dst != {HZ_AW_MAX{1'b0}}) & (e.dst == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input shadow_t m, input shadow_t w,
                                         input logic [HZ_AW_MAX-1:0] r);
    logic [1:0] sel;
    if (match(m, r) && !m.memread) begin
      sel = FWD_MEM;
    end else if (match(w, r)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  always_comb begin
    rs_w  = widen(id_rs);
    rt_w  = widen(id_rt);
    dst_w = widen(id_dst);

    load_haz = id_valid & ex_q.memread &
               ((id_uses_rs & match(ex_q, rs_w)) | (id_uses_rt & match(ex_q, rt_w)));
    hilo_haz = id_valid & cnt_busy & (id_hilo_op | id_hilo_read);
    stall    = (load_haz | hilo_haz) & ~ex_redirect & ~Rst;

    // A redirected DEC instruction is squashed: no EX entry and no HI/LO start.
    issue      = id_valid & ~stall & ~ex_redirect;
    hilo_start = issue & id_hilo_op;

    ex_d = shadow_clear();
    if (issue) begin
      ex_d.valid    = 1'b1;
      ex_d.dst      = dst_w;
      ex_d.rs       = rs_w;
      ex_d.rt       = rt_w;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end else begin
      ex_d = shadow_clear();
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    fwd_a_raw = fwd_sel(mem_q, wb_q, ex_q.rs);
    fwd_b_raw = fwd_sel(mem_q, wb_q, ex_q.rt);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_q  <= shadow_clear();
      mem_q <= shadow_clear();
      wb_q  <= shadow_clear();
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  hilo_busy_counter #(
    .HILO_LAT (HILO_LAT)
  ) u_hilo_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (hilo_start),
    .busy  (cnt_busy)
  );

  always_comb begin
    stall_pc  = stall;
    bubble_ex = (stall | ex_redirect) & ~Rst;
    flush_dec = ex_redirect & ~Rst;
    hilo_busy = cnt_busy & ~Rst;
    if (Rst) begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end else begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
    end
  end

  // MEM/WB carry source indices only to keep one entry shape across stages.
  logic unused_shadow_bits;
  assign unused_shadow_bits = ^{mem_q.rs, mem_q.rt, wb_q.rs, wb_q.rt, wb_q.memread};

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit with hand-computed expectations.
module tb_pipeline_hazard_unit;

  localparam int REG_AW   = 5;
  localparam int HILO_LAT = 4;

  logic              Clk;
  logic              Rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_hilo_op;
  logic              id_hilo_read;
  logic              ex_redirect;
  logic              stall_pc;
  logic              bubble_ex;
  logic              flush_dec;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              hilo_busy;

  int n_total;
  int n_bad;

  pipeline_hazard_unit #(
    .REG_AW   (REG_AW),
    .HILO_LAT (HILO_LAT)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dst       (id_dst),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_hilo_op   (id_hilo_op),
    .id_hilo_read (id_hilo_read),
    .ex_redirect  (ex_redirect),
    .stall_pc     (stall_pc),
    .bubble_ex    (bubble_ex),
    .flush_dec    (flush_dec),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .hilo_busy    (hilo_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Packed view: {stall_pc, bubble_ex, flush_dec, fwd_a, fwd_b, hilo_busy}
  function automatic logic [7:0] pk(input logic s, input logic b, input logic f,
                                    input logic [1:0] fa, input logic [1:0] fb, input logic h);
    return {s, b, f, fa, fb, h};
  endfunction

  function automatic logic [7:0] outs();
    return {stall_pc, bubble_ex, flush_dec, fwd_a, fwd_b, hilo_busy};
  endfunction

  task automatic dec(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                     input int dst, input logic rw, input logic mr, input logic hop, input logic hrd);
    id_valid     = v;
    id_rs        = REG_AW'(rs);
    id_rt        = REG_AW'(rt);
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_dst       = REG_AW'(dst);
    id_regwrite  = rw;
    id_memread   = mr;
    id_hilo_op   = hop;
    id_hilo_read = hrd;
    ex_redirect  = 1'b0;
  endtask

  task automatic idle();
    dec(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  task automatic adv();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) adv();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    Rst = 1'b1;
    idle();
    ex_redirect = 1'b1;
    mid();
    check_eq("reset_outs", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv();
    Rst = 1'b0;
    idle();

    // Load then dependent use
    dec(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
    mid(); check_eq("lw_issue", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv();
    dec(1, 8, 0, 1, 0, 10, 1, 0, 0, 0);
    mid(); check_eq("lu_stall", outs(), pk(1, 1, 0, 2'b00, 2'b00, 0));
    adv();
    mid(); check_eq("lu_release", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv();
    idle();
    mid(); check_eq("lu_fwd_wb", outs(), pk(0, 0, 0, 2'b01, 2'b00, 0));
    drain(3);

    // Back-to-back ALU: MEM forward
    dec(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); adv();
    dec(1, 3, 9, 1, 1, 11, 1, 0, 0, 0);
    mid(); check_eq("alu_nostall", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv(); idle();
    mid(); check_eq("alu_fwd_mem", outs(), pk(0, 0, 0, 2'b00, 2'b10, 0));
    drain(3);

    // One unrelated instruction between: WB forward
    dec(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); adv();
    dec(1, 1, 2, 1, 1, 12, 1, 0, 0, 0); adv();
    dec(1, 3, 9, 1, 1, 11, 1, 0, 0, 0); adv();
    idle();
    mid(); check_eq("alu_fwd_wb", outs(), pk(0, 0, 0, 2'b00, 2'b01, 0));
    drain(3);

    // Two producers of r9: youngest (MEM) wins
    dec(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); adv();
    dec(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); adv();
    dec(1, 9, 9, 1, 1, 11, 1, 0, 0, 0); adv();
    idle();
    mid(); check_eq("fwd_youngest", outs(), pk(0, 0, 0, 2'b10, 2'b10, 0));
    drain(3);

    // Load in MEM is never MEM-forwarded (rt not read, so no stall)
    dec(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); adv();
    dec(1, 0, 9, 0, 0, 11, 1, 0, 0, 0);
    mid(); check_eq("lw_rt_unused", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv(); idle();
    mid(); check_eq("no_mem_fwd_load", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    drain(3);

    // $zero: load to r0 causes no stall, ALU to r0 no forward
    dec(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); adv();
    dec(1, 0, 0, 1, 1, 13, 1, 0, 0, 0);
    mid(); check_eq("zero_no_stall", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    drain(3);
    dec(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); adv();
    dec(1, 0, 0, 1, 1, 13, 1, 0, 0, 0); adv();
    idle();
    mid(); check_eq("zero_no_fwd", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    drain(3);

    // HI/LO: mult then mflo stalls while the counter runs 4..1
    dec(1, 4, 5, 1, 1, 0, 0, 0, 1, 0);
    mid(); check_eq("mult_issue", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv();
    dec(1, 0, 0, 0, 0, 2, 1, 0, 0, 1);
    for (int k = 0; k < HILO_LAT; k++) begin
      mid(); check_eq($sformatf("hilo_stall%0d", k), outs(), pk(1, 1, 0, 2'b00, 2'b00, 1));
      adv();
    end
    mid(); check_eq("hilo_issue", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    drain(3);

    // Simultaneous load-use and HI/LO hazard: single stall until both clear
    dec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); adv();
    dec(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    mid(); check_eq("lw_during_busy", outs(), pk(0, 0, 0, 2'b00, 2'b00, 1));
    adv();
    dec(1, 5, 0, 1, 0, 6, 1, 0, 0, 1);
    for (int k = 0; k < HILO_LAT - 1; k++) begin
      mid(); check_eq($sformatf("dual_stall%0d", k), outs(), pk(1, 1, 0, 2'b00, 2'b00, 1));
      adv();
    end
    mid(); check_eq("dual_release", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    drain(3);

    // Redirect beats load-use; squashed load never reaches EX
    dec(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); adv();
    dec(1, 7, 0, 1, 0, 6, 1, 1, 0, 0);
    ex_redirect = 1'b1;
    mid(); check_eq("redirect_vs_stall", outs(), pk(0, 1, 1, 2'b00, 2'b00, 0));
    adv();
    dec(1, 6, 0, 1, 0, 14, 1, 0, 0, 0);
    mid(); check_eq("squashed_not_in_ex", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    drain(3);

    // Squashed mult must not start the HI/LO counter
    dec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    ex_redirect = 1'b1;
    adv(); idle();
    mid(); check_eq("squashed_mult", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    drain(2);

    // Reset during HI/LO busy with a load in EX
    dec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); adv();
    dec(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); adv();
    dec(1, 4, 0, 1, 0, 15, 1, 0, 0, 1);
    mid(); check_eq("pre_reset_stall", outs(), pk(1, 1, 0, 2'b00, 2'b00, 1));
    Rst = 1'b1;
    #1; check_eq("in_reset_outs", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv();
    Rst = 1'b0;
    idle();
    mid(); check_eq("post_reset_idle", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv();
    dec(1, 4, 4, 1, 1, 16, 1, 0, 0, 1);
    mid(); check_eq("post_reset_nostall", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    adv(); idle();
    mid(); check_eq("post_reset_fwd", outs(), pk(0, 0, 0, 2'b00, 2'b00, 0));
    drain(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
